psum_ofifo: RTL and testbench



---
 rtl/psum_ofifo.sv | 58 +++++
 tb/tb_psum_ofifo.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/psum_ofifo.sv
// psum_ofifo: per-column partial-sum queues that release one aligned row once every column holds data
module psum_ofifo #(
  parameter int col = 8,
  parameter int psum_bw = 16,
  parameter int depth = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [col-1:0]         wr,
  input  logic [psum_bw*col-1:0] in,
  input  logic                   rd,
  output logic [psum_bw*col-1:0] out,
  output logic                   o_valid,
  output logic                   o_full,
  output logic                   o_ready,
  output logic [col-1:0]         o_overflow
);
  localparam int aw = $clog2(depth);
  localparam logic [aw:0] full_c = (aw+1)'(depth);
  logic [col-1:0] nz, fl;
  logic pop;
  assign pop = rd & o_valid;
  assign o_valid = &nz;
  assign o_full = |fl;
  assign o_ready = ~o_full;
  genvar i;
  for (i = 0; i < col; i++) begin : g_col
    logic [psum_bw-1:0] mem [depth];
    logic [psum_bw-1:0] q;
    logic [aw-1:0] wp, rp;
    logic [aw:0] cnt;
    logic ov, push;
    // a full column still accepts when the row pop frees a slot in the same cycle
    assign push = wr[i] & ((cnt != full_c) | pop);
    assign nz[i] = cnt != '0;
    assign fl[i] = cnt == full_c;
    assign out[psum_bw*i +: psum_bw] = q;
    assign o_overflow[i] = ov;
    always_ff @(posedge clk)
      if (push) mem[wp] <= in[psum_bw*i +: psum_bw];
    always_ff @(posedge clk or posedge reset)
      if (reset) begin
        wp <= '0;
        rp <= '0;
        cnt <= '0;
        q <= '0;
        ov <= 1'b0;
      end else begin
        if (push) wp <= wp + aw'(1);
        if (pop) begin
          rp <= rp + aw'(1);
          q <= mem[rp];
        end
        if (push != pop) cnt <= push ? cnt + (aw+1)'(1) : cnt - (aw+1)'(1);
        if (wr[i] & ~push) ov <= 1'b1;
      end
  end
endmodule

// File: tb/tb_psum_ofifo.sv
// tb_psum_ofifo: directed checks of fill skew, partial rows, full/overflow, wrap-around and async reset
module tb_psum_ofifo;
  logic clk, reset, rd, o_valid, o_full, o_ready;
  logic [7:0] wr, o_overflow;
  logic [127:0] in, out, hold;
  int passed = 0, total = 0;

  psum_ofifo #(.col(8), .psum_bw(16), .depth(16)) dut (
    .clk(clk), .reset(reset), .wr(wr), .in(in), .rd(rd), .out(out),
    .o_valid(o_valid), .o_full(o_full), .o_ready(o_ready), .o_overflow(o_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] rep(input logic [15:0] v);
    logic [127:0] r;
    for (int k = 0; k < 8; k++) r[16*k +: 16] = v;
    return r;
  endfunction

  function automatic logic [127:0] rowinc(input logic [15:0] v);
    logic [127:0] r;
    for (int k = 0; k < 8; k++) r[16*k +: 16] = v + 16'(k);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic cyc(input logic [7:0] w, input logic [127:0] d, input logic r);
    wr = w;
    in = d;
    rd = r;
    @(posedge clk);
    #1;
    wr = '0;
    rd = 1'b0;
  endtask

  task automatic pulse_reset();
    #2 reset = 1'b1;
    #3 reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    wr = '0;
    in = '0;
    rd = 1'b0;
    #12 reset = 1'b0;
    chk("rst_out", out, '0);
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_full", o_full, 1'b0);
    chk("rst_ready", o_ready, 1'b1);
    chk("rst_ovf", o_overflow, 8'h00);
    @(posedge clk);
    #1;
    cyc(8'hFF, rep(16'h1234), 1'b0);
    cyc(8'h00, '0, 1'b1);
    chk("pre_async_out", out, rep(16'h1234));
    cyc(8'hFF, rep(16'h4321), 1'b0);
    chk("pre_async_valid", o_valid, 1'b1);
    pulse_reset();
    chk("async_out", out, '0);
    chk("async_valid", o_valid, 1'b0);
    chk("async_ready", o_ready, 1'b1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) begin
      cyc(8'(1 << i), rowinc(16'hFFFB), 1'b0);
      chk($sformatf("skew_valid%0d", i), o_valid, (i == 7));
    end
    cyc(8'h00, '0, 1'b1);
    chk("skew_out", out, rowinc(16'hFFFB));
    chk("skew_valid_after", o_valid, 1'b0);

    for (int k = 0; k < 4; k++) begin
      cyc(8'h7F, rep(16'h0055), 1'b0);
      chk($sformatf("partial_valid%0d", k), o_valid, 1'b0);
    end
    cyc(8'h00, '0, 1'b1);
    cyc(8'h00, '0, 1'b1);
    chk("partial_out_hold", out, rowinc(16'hFFFB));
    chk("partial_valid_rd", o_valid, 1'b0);

    pulse_reset();
    @(posedge clk);
    #1;
    for (int k = 0; k < 16; k++) begin
      cyc(8'hFF, rep(16'(k)), 1'b0);
      if (k == 14) chk("full_at15", o_full, 1'b0);
    end
    chk("full16", o_full, 1'b1);
    chk("ready16", o_ready, 1'b0);
    cyc(8'hFF, rep(16'h0099), 1'b0);
    chk("ovf_set", o_overflow, 8'hFF);
    chk("ovf_full", o_full, 1'b1);
    for (int k = 0; k < 16; k++) begin
      cyc(8'h00, '0, 1'b1);
      chk($sformatf("drain%0d", k), out, rep(16'(k)));
    end
    chk("drain_valid", o_valid, 1'b0);
    chk("ovf_sticky", o_overflow, 8'hFF);

    pulse_reset();
    @(posedge clk);
    #1;
    for (int k = 0; k < 16; k++) cyc(8'hFF, rep(16'(k)), 1'b0);
    cyc(8'hFF, rep(16'h00AA), 1'b1);
    chk("rw_full_out", out, rep(16'h0000));
    chk("rw_full", o_full, 1'b1);
    chk("rw_ovf", o_overflow, 8'h00);
    for (int k = 1; k <= 16; k++) begin
      cyc(8'h00, '0, 1'b1);
      chk($sformatf("rw_drain%0d", k), out, (k == 16) ? rep(16'h00AA) : rep(16'(k)));
    end
    chk("rw_empty", o_valid, 1'b0);

    pulse_reset();
    @(posedge clk);
    #1;
    cyc(8'hFF, rep(16'd0), 1'b0);
    for (int k = 1; k <= 40; k++) begin
      cyc((k < 40) ? 8'hFF : 8'h00, rep(16'(k)), 1'b1);
      chk($sformatf("wrap%0d", k - 1), out, rep(16'(k - 1)));
    end
    chk("wrap_empty", o_valid, 1'b0);
    cyc(8'hFF, rep(16'd7), 1'b0);
    cyc(8'hFF, rep(16'd8), 1'b0);
    cyc(8'hFF, rep(16'd9), 1'b1);
    hold = out;
    chk("mid_out", hold, rep(16'd7));
    pulse_reset();
    chk("mid_rst_out", out, '0);
    chk("mid_rst_valid", o_valid, 1'b0);
    @(posedge clk);
    #1;
    cyc(8'hFF, rep(16'd50), 1'b0);
    cyc(8'h00, '0, 1'b1);
    chk("post_rst_out", out, rep(16'd50));
    chk("post_rst_valid", o_valid, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
